// File: rtl/capture_pkg.sv
// Shared types and constants for the ADC sample capture path.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    WR   = 2'd3
  } cap_state_e;

  localparam logic [3:0] BYTEEN_FULL = 4'b1111;
  localparam logic [3:0] BYTEEN_LO   = 4'b0011;

  // Default ring placement, mirrored in the software headers.
  localparam int DEFAULT_BASE_ADDR = 20000;
  localparam int DEFAULT_BUF_WORDS = 4096;

  // Width of the frame length and word counter.
  localparam int FRAME_W = 13;

  // A programmed frame length of zero behaves as a one-word frame.
  function automatic logic [FRAME_W-1:0] frame_len(input logic [FRAME_W-1:0] fw);
    return (fw == '0) ? FRAME_W'(1) : fw;
  endfunction

endpackage

// File: rtl/ring_addr_counter.sv
// Circular write pointer over the capture buffer plus the per-frame word count.
module ring_addr_counter
  import capture_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int BUF_WORDS = DEFAULT_BUF_WORDS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               adv,
  input  logic [FRAME_W-1:0] frame_len_q,
  output logic [ADDR_W-1:0]  wr_ptr,
  output logic [FRAME_W-1:0] word_cnt,
  output logic               last
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] FINAL_ADDR = ADDR_W'(BASE_ADDR + BUF_WORDS - 1);

  // Advance the ring pointer on every granted write, wrapping at the buffer end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= FIRST_ADDR;
    end else if (adv) begin
      wr_ptr <= (wr_ptr == FINAL_ADDR) ? FIRST_ADDR : wr_ptr + ADDR_W'(1);
    end
  end

  // Count words written in the current frame; cleared when a frame starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt <= '0;
    end else if (clr) begin
      word_cnt <= '0;
    end else if (adv) begin
      word_cnt <= word_cnt + FRAME_W'(1);
    end
  end

  // The write in flight is the final word of the frame.
  assign last = ((word_cnt + FRAME_W'(1)) == frame_len_q);

endmodule

// File: rtl/sample_capture_writer.sv
// Packs 16-bit ADC samples two per word and writes them into a ring in on-chip memory.
module sample_capture_writer
  import capture_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int BUF_WORDS = DEFAULT_BUF_WORDS,
  parameter int SAMPLE_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [FRAME_W-1:0]    frame_words,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample_data,
  output logic                  sample_ready,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [3:0]            mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [2*SAMPLE_W-1:0] mem_writedata,
  output logic                  mem_clken,
  input  logic                  mem_grant,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  irq,
  input  logic                  irq_ack,
  output logic [ADDR_W-1:0]     wr_ptr
);

  localparam int WORD_W = 2 * SAMPLE_W;

  cap_state_e          state, state_n;
  logic [FRAME_W-1:0]  frame_len_q;
  logic [FRAME_W-1:0]  word_cnt;
  logic                stop_pend, stop_pend_n;
  logic [WORD_W-1:0]   wdata_n;
  logic [3:0]          byteen_n;
  logic                frame_done_n;
  logic                accept, adv, clr, last, frame_end;

  assign accept    = sample_valid & sample_ready;
  assign adv       = (state == WR) & mem_grant;
  // stop wins over a simultaneous start
  assign clr       = (state == IDLE) & start & ~stop;
  // a half-filled flush never counts as the end of a frame
  assign frame_end = last & (mem_byteenable == BYTEEN_FULL);

  assign mem_clken   = 1'b1;
  assign mem_address = wr_ptr;

  ring_addr_counter #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .BUF_WORDS (BUF_WORDS)
  ) u_ring (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr         (clr),
    .adv         (adv),
    .frame_len_q (frame_len_q),
    .wr_ptr      (wr_ptr),
    .word_cnt    (word_cnt),
    .last        (last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and next-output decode; a sample presented alongside stop is discarded.
  always_comb begin
    state_n      = state;
    stop_pend_n  = stop_pend;
    wdata_n      = mem_writedata;
    byteen_n     = mem_byteenable;
    frame_done_n = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          state_n     = LO;
          stop_pend_n = 1'b0;
        end
      end
      LO: begin
        if (stop) begin
          state_n = IDLE;
        end else if (accept) begin
          wdata_n[SAMPLE_W-1:0] = sample_data;
          state_n               = HI;
        end
      end
      HI: begin
        if (stop) begin
          byteen_n    = BYTEEN_LO;
          stop_pend_n = 1'b1;
          state_n     = WR;
        end else if (accept) begin
          wdata_n[WORD_W-1:SAMPLE_W] = sample_data;
          byteen_n                   = BYTEEN_FULL;
          state_n                    = WR;
        end
      end
      WR: begin
        if (stop) begin
          stop_pend_n = 1'b1;
        end
        if (mem_grant) begin
          stop_pend_n  = 1'b0;
          frame_done_n = frame_end;
          state_n      = (stop_pend || stop || frame_end) ? IDLE : LO;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_ready   <= 1'b0;
      mem_write      <= 1'b0;
      mem_chipselect <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      irq            <= 1'b0;
      stop_pend      <= 1'b0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
      frame_len_q    <= FRAME_W'(1);
    end else begin
      sample_ready   <= (state_n == LO) || (state_n == HI);
      mem_write      <= (state_n == WR);
      mem_chipselect <= (state_n == WR);
      busy           <= (state_n != IDLE);
      frame_done     <= frame_done_n;
      // setting beats acknowledging, both on the completing write and during the pulse
      irq            <= frame_done_n | frame_done | (irq & ~irq_ack);
      stop_pend      <= stop_pend_n;
      mem_byteenable <= byteen_n;
      mem_writedata  <= wdata_n;
      if (clr) begin
        frame_len_q <= frame_len(frame_words);
      end
    end
  end

endmodule

// File: doc/sample_capture_writer.md
# sample_capture_writer

Upstream write stage for the Nios II on-chip memory. It accepts a stream of 16-bit ADC samples from the three-phase front end and packs them two per 32-bit word. The packed words go into a circular capture buffer in the on-chip memory through the memory's slave write port. When a programmed frame length has been written, it raises an interrupt so Nios II software can run the power analysis on the buffered frame.

## Interface
Parameters:
- ADDR_W, 15, word-address width of the on-chip memory port.
- BASE_ADDR, 20000, first word address of the capture buffer.
- BUF_WORDS, 4096, ring size in words; BASE_ADDR+BUF_WORDS must be ≤ 25000.
- SAMPLE_W, 16, sample width; it is fixed, and two samples make one 32-bit word.

Ports:
- clk  in  1  system clock; the block uses this one clock only.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; latches frame_words and begins capture.
- stop  in  1  single-cycle pulse; ends capture early and flushes any half-filled word.
- frame_words  in  13  number of words per frame, 1..BUF_WORDS; a value of 0 is treated as 1.
- sample_valid  in  1  upstream sample is present.
- sample_data  in  16  sample value.
- sample_ready  out  1  block can accept a sample.
- mem_address  out  ADDR_W  word address.
- mem_byteenable  out  4  byte lanes to write.
- mem_chipselect  out  1  asserted together with mem_write.
- mem_write  out  1  write request.
- mem_writedata  out  32  packed word; the first sample goes in [15:0], the second in [31:16].
- mem_clken  out  1  held at constant 1.
- mem_grant  in  1  arbiter accepts the write on this cycle.
- busy  out  1  block is not in IDLE.
- frame_done  out  1  single-cycle pulse when a frame completes.
- irq  out  1  level interrupt; set by frame_done, cleared by irq_ack.
- irq_ack  in  1  single-cycle pulse from software.
- wr_ptr  out  ADDR_W  next word address that will be written.

## Operation
- States are IDLE, LO, HI and WR.
- IDLE: sample_ready is 0. start loads frame_words, clears the word counter and moves to LO. wr_ptr is not reset by start, so the ring continues from where it stopped.
- LO: sample_ready is 1. An accepted sample (valid & ready) is stored in [15:0] and the state moves to HI.
- HI: sample_ready is 1. An accepted sample is stored in [31:16], byteenable is set to 4'b1111, and the state moves to WR.
- WR: sample_ready is 0, and mem_write and mem_chipselect are 1. On a cycle with mem_grant=1:
  - wr_ptr increments; at BASE_ADDR+BUF_WORDS-1 it wraps to BASE_ADDR.
  - word_cnt increments.
  - If word_cnt+1 == frame_words: pulse frame_done, set irq, go to IDLE. Otherwise go to LO.
- stop in LO or IDLE: go to IDLE with no write.
- stop in HI: write the half-filled word with byteenable 4'b0011, then go to IDLE. frame_done is not pulsed.
- stop in WR: the pending write still completes, then the block goes to IDLE. frame_done fires only if that write completes the frame.
- start while busy is ignored.
- irq_ack and frame_done in the same cycle: irq stays 1, because set wins.

## Timing
- Reset values:
  - state is IDLE.
  - sample_ready, mem_write, mem_chipselect, frame_done, irq and busy are 0.
  - mem_byteenable is 0.
  - mem_writedata is 0.
  - wr_ptr is BASE_ADDR.
  - mem_clken is 1.
- All outputs except mem_clken are registered.
- mem_write rises on the cycle after the second sample of a word is accepted.
- With mem_grant held at 1, the write lasts one cycle and the block returns to LO. Peak throughput is 2 samples per 3 cycles.
- mem_address, mem_writedata and mem_byteenable stay stable while mem_write=1 and mem_grant=0.
- frame_done is asserted on the cycle after the granted final write. irq rises on the same cycle.
- Deassertion of reset_n mid-frame abandons any partial word, with no write issued.

## Structure
- The shared package `capture_pkg` holds:
  - the state enum (IDLE/LO/HI/WR);
  - BYTEEN_FULL = 4'b1111 and BYTEEN_LO = 4'b0011;
  - the default BASE_ADDR and BUF_WORDS values, also used by software headers.
- One sub-module is natural: `ring_addr_counter`, which handles wr_ptr increment, wrap and word_cnt.

## Test plan
- Frame fill: frame_words=2, samples 0x1111, 0x2222, 0x3333, 0x4444, mem_grant=1 → writes 0x22221111 at 20000 and 0x44443333 at 20001, each with byteenable 1111; one frame_done; irq=1; wr_ptr=20002.
- Back-pressure: mem_grant=0 for 5 cycles during WR → address, data and byteenable held; sample_ready=0; exactly one write on grant.
- Wrap: BUF_WORDS=4, two frames with frame_words=3 → addresses 20000, 20001, 20002, 20003, 20000, 20001.
- Early stop: start, one sample 0xABCD, then stop → one write 0x????ABCD with byteenable 0011; no frame_done; busy=0.
- Interrupt: frame_done in the same cycle as irq_ack → irq stays 1; a later irq_ack → irq=0.
- Reset mid-word in HI → all outputs return to their reset values and no memory write occurs.
